hit_manager: RTL and testbench
==============================

# hit_manager

Converts raw collision and test-hit events into debounced player hits with an invulnerability window, and tracks remaining HP and game-over. Sits directly upstream of `hp_control`. It consumes the `colision_detector` damage level and the `monostable` test pulse, and drives `player_hit` as a clean one-cycle pulse. It also exports `hp`, `invulnerable`, `blink` and `game_over` for drawing stages and menu logic. Runs entirely in the `pclk` (65 MHz) domain.

## Interface
Parameters:
- `MAX_HP`, default 8: HP loaded at game start; must be ≥1.
- `INVULN_CYCLES`, default 65_000_000: invulnerability length in `pclk` cycles (1 s); must be ≥2.
- `BLINK_BIT`, default 22: bit of the invulnerability counter driving `blink`; must be < counter width.

Ports:
- `pclk`, in, 1: pixel clock; sole clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `game_on`, in, 1: level, high while gameplay is active (mouse_mode).
- `damage_in`, in, 1: level, high while the cursor overlaps an obstacle.
- `test_hit`, in, 1: one-cycle forced-hit pulse.
- `player_hit`, out, 1: one-cycle pulse per accepted hit.
- `hp`, out, `$clog2(MAX_HP+1)`: remaining HP.
- `invulnerable`, out, 1: high in INVULN.
- `blink`, out, 1: counter[`BLINK_BIT`] while in INVULN, else 0.
- `game_over`, out, 1: high in DEAD.

## Operation
- States: IDLE, ARMED, INVULN, DEAD.
- Reset values: state=IDLE, `hp`=MAX_HP, counter=0, and all 1-bit outputs 0.
- IDLE: `hp` is held at MAX_HP. When `game_on`=1, go to ARMED.
- ARMED: `hit_req = damage_in | test_hit`. Detection is level-sensitive, so sitting inside an obstacle keeps producing hits, one per window. On `hit_req`:
  - Assert `player_hit` and set `hp` to `hp-1`.
  - If the old `hp` was 1, go to DEAD.
  - Otherwise go to INVULN and load the counter with INVULN_CYCLES-1.
- INVULN: the counter decrements each cycle. All `hit_req` are ignored and produce no queued hit. When counter==0, go to ARMED.
- DEAD: `game_over`=1. `hp` holds 0 and further hits are ignored.
- `game_on`=0 in any state forces IDLE on the next edge: `hp` reloads to MAX_HP, the counter clears and `player_hit` is not asserted. This has priority over a simultaneous `hit_req`.
- `hp` never underflows and never exceeds MAX_HP.
- `player_hit` is never high on two consecutive cycles.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- A `hit_req` sampled on rising edge k in ARMED produces the following at k, visible in cycle k+1:
  - `player_hit`=1 for exactly one cycle.
  - `hp` decremented.
  - `invulnerable`=1, or `game_over`=1 on the final hit.
- `invulnerable` stays high for exactly INVULN_CYCLES cycles. A hit can next be accepted on the edge after it falls, so the minimum spacing between `player_hit` pulses is INVULN_CYCLES+1 cycles.
- `rst_n` low at any time asynchronously clears to reset values, including mid-INVULN.
- Leaving IDLE for ARMED takes one cycle after `game_on` rises. A hit present in that same cycle is not accepted until ARMED.

## Structure
- Package `game_pkg`:
  - `hm_state_t` enum, 2-bit encoding: IDLE=0, ARMED=1, INVULN=2, DEAD=3.
  - Shared HP default constant, used by both `hp_control` and this block.
- Sub-module `invuln_timer`: loadable down-counter with inputs `load` and `clear`, outputs `count` and `done` (count==0). Uses the same `pclk`/`rst_n` as this block.
- The FSM and HP register live in `hit_manager`.

## Test plan
Bench parameters: MAX_HP=3, INVULN_CYCLES=16, BLINK_BIT=2.
1. Reset, then `game_on`=1, then a single `test_hit` → one `player_hit` pulse, `hp` 3→2, `invulnerable` high for exactly 16 cycles, `blink` toggling every 4 cycles.
2. Hold `damage_in`=1 continuously → `player_hit` pulses 17 cycles apart, `hp` 3→2→1→0, `game_over`=1 after the third pulse, and no fourth pulse.
3. Pulse `test_hit` during INVULN at cycles 1, 8 and 15 of the window → no `player_hit` and `hp` unchanged.
4. In DEAD, drop `game_on` → IDLE next cycle, `hp`=3, `game_over`=0. Raising `game_on` again re-arms the block.
5. Assert `damage_in` and drop `game_on` in the same cycle while in ARMED → no `player_hit`, `hp`=3, state IDLE.
6. Pull `rst_n` low mid-INVULN, 5 cycles in → immediately `hp`=3, `invulnerable`=0, `blink`=0, `player_hit`=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide types and constants for the hit/HP path.
package game_pkg;

  // Hit manager FSM encoding; the values are visible to the menu/draw logic.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StInvuln = 2'd2,
    StDead   = 2'd3
  } hm_state_t;

  // HP loaded at game start, shared with hp_control.
  localparam int unsigned GameMaxHp = 8;

  // One second of invulnerability at 65 MHz.
  localparam int unsigned GameInvulnCycles = 65_000_000;

  // Counter bit giving a visible blink rate during invulnerability.
  localparam int unsigned GameBlinkBit = 22;

endpackage

// File: rtl/invuln_timer.sv
// Loadable down-counter that times the invulnerability window.
module invuln_timer #(
  parameter int unsigned Width = 26
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             done
);

  logic [Width-1:0] r_count_q;
  logic [Width-1:0] r_count_d;

  // Clear wins over load; otherwise count down and rest at zero.
  always_comb begin
    r_count_d = r_count_q;
    if (clear) begin
      r_count_d = '0;
    end else if (load) begin
      r_count_d = load_val;
    end else if (r_count_q != '0) begin
      r_count_d = r_count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= r_count_d;
    end
  end

  assign count = r_count_q;
  assign done  = (r_count_q == '0);

endmodule

// File: rtl/hit_manager.sv
// Turns raw collision/test-hit levels into debounced one-cycle player hits,
// with an invulnerability window, HP tracking and game-over.
module hit_manager
  import game_pkg::*;
#(
  parameter int unsigned MAX_HP        = GameMaxHp,
  parameter int unsigned INVULN_CYCLES = GameInvulnCycles,
  parameter int unsigned BLINK_BIT     = GameBlinkBit,
  localparam int unsigned HpW          = $clog2(MAX_HP + 1),
  localparam int unsigned CntW         = $clog2(INVULN_CYCLES)
) (
  input  logic           pclk,
  input  logic           rst_n,
  input  logic           game_on,
  input  logic           damage_in,
  input  logic           test_hit,
  output logic           player_hit,
  output logic [HpW-1:0] hp,
  output logic           invulnerable,
  output logic           blink,
  output logic           game_over
);

  localparam logic [HpW-1:0]  HpFull  = HpW'(MAX_HP);
  localparam logic [CntW-1:0] LoadVal = CntW'(INVULN_CYCLES - 1);

  hm_state_t       r_state_q, r_state_d;
  logic [HpW-1:0]  r_hp_q, r_hp_d;
  logic            r_hit_q, r_hit_d;

  logic            w_hit_req;
  logic            w_load;
  logic            w_clear;
  logic            w_done;
  logic [CntW-1:0] w_count;

  assign w_hit_req = damage_in | test_hit;

  invuln_timer #(
    .Width(CntW)
  ) u_invuln_timer (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .load    (w_load),
    .clear   (w_clear),
    .load_val(LoadVal),
    .count   (w_count),
    .done    (w_done)
  );

  // Next-state, HP update and hit pulse; leaving gameplay overrides everything.
  always_comb begin
    r_state_d = r_state_q;
    r_hp_d    = r_hp_q;
    r_hit_d   = 1'b0;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    if (!game_on) begin
      r_state_d = StIdle;
      r_hp_d    = HpFull;
      w_clear   = 1'b1;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          r_hp_d    = HpFull;
          r_state_d = StArmed;
        end
        StArmed: begin
          // hp is never 0 here, the guard only keeps underflow impossible.
          if (w_hit_req && (r_hp_q != '0)) begin
            r_hit_d = 1'b1;
            r_hp_d  = r_hp_q - 1'b1;
            if (r_hp_q == HpW'(1)) begin
              r_state_d = StDead;
            end else begin
              r_state_d = StInvuln;
              w_load    = 1'b1;
            end
          end
        end
        StInvuln: begin
          if (w_done) begin
            r_state_d = StArmed;
          end
        end
        StDead: begin
          r_hp_d = '0;
        end
        default: begin
          r_state_d = StIdle;
        end
      endcase
    end
  end

  // State, HP and hit-pulse registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= StIdle;
      r_hp_q    <= HpFull;
      r_hit_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_hp_q    <= r_hp_d;
      r_hit_q   <= r_hit_d;
    end
  end

  // Outputs decode registers only, so nothing is combinational from inputs.
  assign player_hit   = r_hit_q;
  assign hp           = r_hp_q;
  assign invulnerable = (r_state_q == StInvuln);
  assign game_over    = (r_state_q == StDead);
  assign blink        = (r_state_q == StInvuln) & w_count[BLINK_BIT];

endmodule

// File: tb/tb_hit_manager.sv
// Scoreboard bench for hit_manager: stimulus queues expected hit pulses,
// a negedge monitor pops and checks them as the DUT raises player_hit.
module tb_hit_manager;

  localparam int unsigned MaxHp  = 3;
  localparam int unsigned Invuln = 16;
  localparam int unsigned Blink  = 2;

  typedef struct {
    int hp;
    int go;
    int inv;
    int gap;  // expected cycles since previous pulse, 0 = don't care
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_on = 1'b0;
  logic       damage_in = 1'b0;
  logic       test_hit = 1'b0;
  logic       player_hit;
  logic [1:0] hp;
  logic       invulnerable;
  logic       blink;
  logic       game_over;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_hits = 0;
  int   last_hit_cyc = 0;
  logic prev_hit = 1'b0;
  exp_t sb[$];

  hit_manager #(
    .MAX_HP       (MaxHp),
    .INVULN_CYCLES(Invuln),
    .BLINK_BIT    (Blink)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .game_on     (game_on),
    .damage_in   (damage_in),
    .test_hit    (test_hit),
    .player_hit  (player_hit),
    .hp          (hp),
    .invulnerable(invulnerable),
    .blink       (blink),
    .game_over   (game_over)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic expect_hit(input int e_hp, input int e_go, input int e_inv, input int e_gap);
    exp_t e;
    e.hp  = e_hp;
    e.go  = e_go;
    e.inv = e_inv;
    e.gap = e_gap;
    sb.push_back(e);
  endtask

  // Monitor: every player_hit pulse must match the head of the scoreboard.
  always @(negedge pclk) begin
    exp_t e;
    if (rst_n) begin
      if (player_hit) begin
        chk("hit_back_to_back", int'(prev_hit), 0);
        n_hits++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit actual hp %0d at cycle %0d required no pulse", hp, cyc);
        end else begin
          e = sb.pop_front();
          chk("hit_hp", int'(hp), e.hp);
          chk("hit_game_over", int'(game_over), e.go);
          chk("hit_invulnerable", int'(invulnerable), e.inv);
          if (e.gap != 0) chk("hit_gap", cyc - last_hit_cyc, e.gap);
        end
        last_hit_cyc = cyc;
      end
      prev_hit = player_hit;
    end else begin
      prev_hit = 1'b0;
    end
  end

  initial begin
    int n;
    int base;
    logic [15:0] bpat;

    // Reset values.
    repeat (3) step();
    chk("rst_hp", int'(hp), 3);
    chk("rst_player_hit", int'(player_hit), 0);
    chk("rst_invulnerable", int'(invulnerable), 0);
    chk("rst_game_over", int'(game_over), 0);
    rst_n = 1'b1;
    step();

    // game_on with a hit in the same cycle: not accepted until ARMED.
    game_on  = 1'b1;
    test_hit = 1'b1;
    step();
    test_hit = 1'b0;
    chk("idle_hit_ignored", int'(player_hit), 0);
    chk("idle_hp", int'(hp), 3);

    // Test 1: single test_hit, 16-cycle window, blink every 4 cycles.
    test_hit = 1'b1;
    expect_hit(2, 0, 1, 0);
    step();
    test_hit = 1'b0;
    n = 0;
    bpat = '0;
    while (invulnerable && n < 100) begin
      if (n < 16) bpat[n] = blink;
      n++;
      step();
    end
    chk("invuln_len", n, 16);
    chk("blink_pattern", int'(bpat), 16'h0F0F);
    chk("t1_hp", int'(hp), 2);
    chk("t1_blink_off", int'(blink), 0);

    // Test 3: hits at window cycles 1, 8, 15 are ignored.
    test_hit = 1'b1;
    expect_hit(1, 0, 1, 0);
    step();
    for (int i = 1; i <= 16; i++) begin
      test_hit = (i == 1 || i == 8 || i == 15);
      step();
    end
    test_hit = 1'b0;
    chk("t3_hp", int'(hp), 1);
    chk("t3_invuln_done", int'(invulnerable), 0);
    step();
    chk("t3_no_hit", int'(player_hit), 0);

    // Test 5: damage and game_on drop together in ARMED.
    damage_in = 1'b1;
    game_on   = 1'b0;
    step();
    chk("t5_player_hit", int'(player_hit), 0);
    chk("t5_hp", int'(hp), 3);
    chk("t5_invulnerable", int'(invulnerable), 0);
    chk("t5_game_over", int'(game_over), 0);
    damage_in = 1'b0;
    step();
    game_on = 1'b1;
    step();

    // Test 2: continuous damage, pulses 17 apart, death on the third.
    base = n_hits;
    expect_hit(2, 0, 1, 0);
    expect_hit(1, 0, 1, 17);
    expect_hit(0, 1, 0, 17);
    damage_in = 1'b1;
    n = 0;
    while (n_hits - base < 3 && n < 60) begin
      n++;
      step();
    end
    chk("t2_pulse_count", n_hits - base, 3);
    repeat (40) step();
    chk("t2_no_fourth", n_hits - base, 3);
    chk("t2_hp", int'(hp), 0);
    chk("t2_game_over", int'(game_over), 1);

    // Test 4: leave DEAD via game_on, then re-arm.
    game_on   = 1'b0;
    damage_in = 1'b0;
    step();
    chk("t4_hp", int'(hp), 3);
    chk("t4_game_over", int'(game_over), 0);
    game_on = 1'b1;
    step();
    test_hit = 1'b1;
    expect_hit(2, 0, 1, 0);
    step();
    test_hit = 1'b0;
    chk("t4_rearm_hp", int'(hp), 2);

    // Test 6: asynchronous reset five cycles into the window.
    repeat (4) step();
    chk("t6_pre_invuln", int'(invulnerable), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_hp", int'(hp), 3);
    chk("t6_invulnerable", int'(invulnerable), 0);
    chk("t6_blink", int'(blink), 0);
    chk("t6_player_hit", int'(player_hit), 0);
    @(negedge pclk);
    rst_n = 1'b1;
    step();
    chk("t6_after_invuln", int'(invulnerable), 0);
    chk("t6_after_hp", int'(hp), 3);

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
